// File: rtl/disp2421_pkg.sv
// Shared constants and helpers for the two-digit 2421 display stage.
// Optional invalid-code flagging is selected with DISP2421_INVALID_FLAG_EN.
package disp2421_pkg;

    localparam logic [3:0] C2421_0 = 4'b0000;
    localparam logic [3:0] C2421_1 = 4'b0001;
    localparam logic [3:0] C2421_2 = 4'b0010;
    localparam logic [3:0] C2421_3 = 4'b0011;
    localparam logic [3:0] C2421_4 = 4'b0100;
    localparam logic [3:0] C2421_5 = 4'b1011;
    localparam logic [3:0] C2421_6 = 4'b1100;
    localparam logic [3:0] C2421_7 = 4'b1101;
    localparam logic [3:0] C2421_8 = 4'b1110;
    localparam logic [3:0] C2421_9 = 4'b1111;

    // Segment order is {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [1:0] AN_UNITS = 2'b10;
    localparam logic [1:0] AN_TENS  = 2'b01;

    typedef enum logic {
        SEL_UNITS = 1'b0,
        SEL_TENS  = 1'b1
    } sel_t;

    // Anything outside the legal set falls back to zero so tens stays valid
    function automatic logic [3:0] next2421(input logic [3:0] d);
        case (d)
            C2421_0: next2421 = C2421_1;
            C2421_1: next2421 = C2421_2;
            C2421_2: next2421 = C2421_3;
            C2421_3: next2421 = C2421_4;
            C2421_4: next2421 = C2421_5;
            C2421_5: next2421 = C2421_6;
            C2421_6: next2421 = C2421_7;
            C2421_7: next2421 = C2421_8;
            C2421_8: next2421 = C2421_9;
            default: next2421 = C2421_0;
        endcase
    endfunction

endpackage

// File: rtl/disp2421_scan_code2421_to_seg.sv
// Combinational 2421 to 7-segment decoder with a validity flag.
// Behaviour is the same whether or not DISP2421_INVALID_FLAG_EN is defined.
module code2421_to_seg
    import disp2421_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg,
    output logic       o_valid
);

    always_comb begin
        o_seg   = SEG_BLANK;
        o_valid = 1'b1;
        case (i_code)
            C2421_0: o_seg = SEG_0;
            C2421_1: o_seg = SEG_1;
            C2421_2: o_seg = SEG_2;
            C2421_3: o_seg = SEG_3;
            C2421_4: o_seg = SEG_4;
            C2421_5: o_seg = SEG_5;
            C2421_6: o_seg = SEG_6;
            C2421_7: o_seg = SEG_7;
            C2421_8: o_seg = SEG_8;
            C2421_9: o_seg = SEG_9;
            default: o_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/disp2421_scan.sv
// Two-digit multiplexed display for a 2421 units counter with derived tens.
// Define DISP2421_INVALID_FLAG_EN to show "E" and raise err on invalid units codes.
module disp2421_scan
    import disp2421_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] code_in,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic [3:0] tens,
    output logic       err
);

    localparam logic [15:0] CNT_LAST = 16'(SCAN_DIV - 1);

    logic [3:0]  r_codeQ;
    logic [3:0]  r_tens;
    logic [15:0] r_cnt;
    sel_t        r_sel;
    logic [6:0]  r_seg;
    logic [1:0]  r_an;
    logic        r_err;

    logic [6:0]  w_unitsSeg;
    logic        w_unitsValid;
    logic [6:0]  w_tensSeg;
    logic        w_tensValid;
    logic [6:0]  w_nextSeg;
    logic        w_wrap;

    code2421_to_seg u_unitsDec (
        .i_code  (r_codeQ),
        .o_seg   (w_unitsSeg),
        .o_valid (w_unitsValid)
    );

    code2421_to_seg u_tensDec (
        .i_code  (r_tens),
        .o_seg   (w_tensSeg),
        .o_valid (w_tensValid)
    );

    assign w_wrap = (r_codeQ == C2421_9) && (code_in == C2421_0);

    // Pattern for the digit selected this cycle; invalid units show E or blank
    always_comb begin
        w_nextSeg = SEG_BLANK;
        if (r_sel == SEL_TENS) begin
            w_nextSeg = w_tensValid ? w_tensSeg : SEG_BLANK;
        end else if (w_unitsValid) begin
            w_nextSeg = w_unitsSeg;
        end else begin
`ifdef DISP2421_INVALID_FLAG_EN
            w_nextSeg = SEG_E;
`else
            w_nextSeg = SEG_BLANK;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_codeQ <= C2421_0;
            r_tens  <= C2421_0;
            r_cnt   <= '0;
            r_sel   <= SEL_UNITS;
            r_an    <= AN_UNITS;
            r_seg   <= SEG_0;
            r_err   <= 1'b0;
        end else begin
            r_codeQ <= code_in;
            if (w_wrap) begin
                r_tens <= next2421(r_tens);
            end
            if (r_cnt == CNT_LAST) begin
                r_cnt <= '0;
                r_sel <= (r_sel == SEL_UNITS) ? SEL_TENS : SEL_UNITS;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
            // an and seg both follow the pre-toggle select so they never disagree
            r_an  <= (r_sel == SEL_TENS) ? AN_TENS : AN_UNITS;
            r_seg <= w_nextSeg;
`ifdef DISP2421_INVALID_FLAG_EN
            r_err <= ~w_unitsValid;
`else
            r_err <= 1'b0;
`endif
        end
    end

    assign seg  = r_seg;
    assign an   = r_an;
    assign tens = r_tens;
    assign err  = r_err;

endmodule

// File: tb/tb_disp2421_scan.sv
// Directed, table-driven bench for disp2421_scan with SCAN_DIV=4.
// Expectations for invalid codes follow DISP2421_INVALID_FLAG_EN.
module tb_disp2421_scan;

    logic       clk;
    logic       rst;
    logic [3:0] code_in;
    logic [6:0] seg;
    logic [1:0] an;
    logic [3:0] tens;
    logic       err;

    int total;
    int bad;

`ifdef DISP2421_INVALID_FLAG_EN
    localparam logic [6:0] SEG_INV = 7'h79;
    localparam logic       ERR_INV = 1'b1;
`else
    localparam logic [6:0] SEG_INV = 7'h00;
    localparam logic       ERR_INV = 1'b0;
`endif

    typedef struct {
        logic [3:0] code;
        logic [1:0] an;
        logic [6:0] seg;
        logic       err;
    } vec_t;

    vec_t       vecs [13];
    logic [3:0] tensSeq [10];

    disp2421_scan #(.SCAN_DIV(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .code_in (code_in),
        .seg     (seg),
        .an      (an),
        .tens    (tens),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] code);
        code_in = code;
        tick();
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic doReset(input logic [3:0] code);
        rst     = 1'b1;
        code_in = code;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    initial begin
        int  n;
        bit  found;
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        code_in = 4'b0000;

        vecs[0]  = '{4'b0011, 2'b10, 7'h3F, 1'b0};
        vecs[1]  = '{4'b0011, 2'b10, 7'h4F, 1'b0};
        vecs[2]  = '{4'b1111, 2'b10, 7'h4F, 1'b0};
        vecs[3]  = '{4'b1100, 2'b10, 7'h6F, 1'b0};
        vecs[4]  = '{4'b0100, 2'b01, 7'h3F, 1'b0};
        vecs[5]  = '{4'b0001, 2'b01, 7'h3F, 1'b0};
        vecs[6]  = '{4'b0010, 2'b01, 7'h3F, 1'b0};
        vecs[7]  = '{4'b1110, 2'b01, 7'h3F, 1'b0};
        vecs[8]  = '{4'b1011, 2'b10, 7'h7F, 1'b0};
        vecs[9]  = '{4'b0110, 2'b10, 7'h6D, 1'b0};
        vecs[10] = '{4'b0000, 2'b10, SEG_INV, ERR_INV};
        vecs[11] = '{4'b0000, 2'b10, 7'h3F, 1'b0};
        vecs[12] = '{4'b0000, 2'b01, 7'h3F, 1'b0};

        tensSeq[0] = 4'b0001; tensSeq[1] = 4'b0010; tensSeq[2] = 4'b0011;
        tensSeq[3] = 4'b0100; tensSeq[4] = 4'b1011; tensSeq[5] = 4'b1100;
        tensSeq[6] = 4'b1101; tensSeq[7] = 4'b1110; tensSeq[8] = 4'b1111;
        tensSeq[9] = 4'b0000;

        // Reset holds the display on units "0" despite a live input code
        doReset(4'b1101);
        checkOutput("resetSeg", seg, 7'h3F);
        checkOutput("resetAn", an, 2'b10);
        checkOutput("resetTens", tens, 4'b0000);
        checkOutput("resetErr", err, 1'b0);
        applyStimulus(4'b1101);
        checkOutput("latency1Seg", seg, 7'h3F);
        applyStimulus(4'b1101);
        checkOutput("latency2Seg", seg, 7'h07);

        // Scan cadence, digit patterns and invalid-code handling
        doReset(4'b0011);
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].code);
            checkOutput($sformatf("vec%0d_an", i), an, vecs[i].an);
            checkOutput($sformatf("vec%0d_seg", i), seg, vecs[i].seg);
            checkOutput($sformatf("vec%0d_err", i), err, vecs[i].err);
            checkOutput($sformatf("vec%0d_tens", i), tens, 4'b0000);
        end

        // Ten passes of the full 4-bit counter sequence
        doReset(4'b0000);
        for (int rep = 0; rep < 10; rep++) begin
            for (int v = 0; v < 16; v++) begin
                applyStimulus(4'(v));
                if (v == 0 && rep > 0)
                    checkOutput($sformatf("wrapTens%0d", rep), tens, tensSeq[rep-1]);
                if (v == 15)
                    checkOutput($sformatf("holdTens%0d", rep), tens,
                                (rep == 0) ? 0 : int'(tensSeq[rep-1]));
            end
        end
        applyStimulus(4'b0000);
        checkOutput("wrapTens10", tens, tensSeq[9]);
        for (int v = 1; v < 16; v++) applyStimulus(4'(v));
        applyStimulus(4'b0000);
        checkOutput("wrapTens11", tens, 4'b0001);

        // Transitions that are not a 9->0 wrap must leave tens alone
        applyStimulus(4'b1111);
        applyStimulus(4'b0001);
        checkOutput("jump9to1", tens, 4'b0001);
        applyStimulus(4'b1110);
        applyStimulus(4'b0000);
        checkOutput("jump8to0", tens, 4'b0001);
        applyStimulus(4'b0000);
        applyStimulus(4'b1111);
        checkOutput("jump0to9", tens, 4'b0001);

        // Tens digit must appear on the bus during its window
        found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            applyStimulus(4'b0000);
            if (an == 2'b01) begin
                found = 1'b1;
                checkOutput("tensSeg", seg, 7'h06);
            end
        end
        if (!found) checkOutput("tensWindow", 0, 1);

        // Reset arriving together with a wrap wins
        applyStimulus(4'b1111);
        rst     = 1'b1;
        code_in = 4'b0000;
        tick();
        checkOutput("collisionTens", tens, 4'b0000);
        checkOutput("collisionAn", an, 2'b10);
        checkOutput("collisionSeg", seg, 7'h3F);
        rst = 1'b0;
        n   = 0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            applyStimulus(4'b0000);
            n++;
            if (an == 2'b01) found = 1'b1;
        end
        checkOutput("collisionWindow", n, 5);
        checkOutput("collisionTensHold", tens, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
